// File: rtl/alu_pkg.sv
// Shared command encodings, FSM states and flag positions for the handshaked execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic is_mul_cmd(input logic [3:0] cmd);
    return (cmd == CMD_MUL) || (cmd == CMD_MLA);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and the EX/MEM register.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       status;
  logic             busy;

  modport slave (
    input  in_valid, cmd, in1, in2, in3, carry_in, out_ready,
    output in_ready, out_valid, out, status, busy
  );

  modport master (
    output in_valid, cmd, in1, in2, in3, carry_in, out_ready,
    input  in_ready, out_valid, out, status, busy
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, always exactly WIDTH steps per operation.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             kill_i,
  input  logic             start_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] multiplicand_i,
  input  logic [WIDTH-1:0] multiplier_i,
  input  logic [WIDTH-1:0] acc_init_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The final step's sum is presented combinationally so the top can register it on the done edge.
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = run_i && (cnt_q == LastCnt);
  assign product_o = acc_step;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (kill_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      mcand_d  = multiplicand_i;
      mplier_d = multiplier_i;
      acc_d    = acc_init_i;
      cnt_d    = '0;
    end else if (run_i) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = done_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle base ops, WIDTH-cycle MUL/MLA, result held until consumed.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  alu_mc_if.slave   bus_io
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       status_q, status_d;

  logic             in_ready;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   ext_a, ext_b, sum;
  logic [WIDTH-1:0] alu_res;
  logic             is_add, is_sub;
  logic [3:0]       alu_status, mul_status;

  // Reset gating keeps in_ready low while the block is held in reset.
  assign in_ready = rst_ni && (state_q == ST_IDLE) && (!out_valid_q || bus_io.out_ready) &&
                    !flush_i;
  assign accept   = bus_io.in_valid && in_ready;

  assign ext_a = {1'b0, bus_io.in1};
  assign ext_b = {1'b0, bus_io.in2};

  always_comb begin
    alu_res = '0;
    sum     = '0;
    is_add  = 1'b0;
    is_sub  = 1'b0;
    case (bus_io.cmd)
      CMD_MOV: alu_res = bus_io.in2;
      CMD_MVN: alu_res = ~bus_io.in2;
      CMD_ADD: begin
        sum    = ext_a + ext_b;
        is_add = 1'b1;
      end
      CMD_ADC: begin
        sum    = ext_a + ext_b + {{WIDTH{1'b0}}, bus_io.carry_in};
        is_add = 1'b1;
      end
      CMD_SUB: begin
        sum    = ext_a - ext_b;
        is_sub = 1'b1;
      end
      CMD_SBC: begin
        sum    = ext_a - ext_b - {{WIDTH{1'b0}}, ~bus_io.carry_in};
        is_sub = 1'b1;
      end
      CMD_AND: alu_res = bus_io.in1 & bus_io.in2;
      CMD_ORR: alu_res = bus_io.in1 | bus_io.in2;
      default: alu_res = bus_io.in1 ^ bus_io.in2;
    endcase
    if (is_add || is_sub) alu_res = sum[WIDTH-1:0];
  end

  always_comb begin
    alu_status         = '0;
    alu_status[FLAG_N] = alu_res[WIDTH-1];
    alu_status[FLAG_Z] = (alu_res == '0);
    alu_status[FLAG_C] = (is_add || is_sub) && sum[WIDTH];
    alu_status[FLAG_V] = (is_add && (bus_io.in1[WIDTH-1] == bus_io.in2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus_io.in1[WIDTH-1])) ||
                         (is_sub && (bus_io.in1[WIDTH-1] != bus_io.in2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] == bus_io.in2[WIDTH-1]));
    mul_status         = '0;
    mul_status[FLAG_N] = mul_product[WIDTH-1];
    mul_status[FLAG_Z] = (mul_product == '0);
  end

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul_seq (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .kill_i         (flush_i),
    .start_i        (mul_start),
    .run_i          (state_q == ST_MUL),
    .multiplicand_i (bus_io.in1),
    .multiplier_i   (bus_io.in2),
    .acc_init_i     ((bus_io.cmd == CMD_MLA) ? bus_io.in3 : '0),
    .done_o         (mul_done),
    .product_o      (mul_product)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    status_d    = status_q;
    mul_start   = 1'b0;
    if (flush_i) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && bus_io.out_ready) out_valid_d = 1'b0;
      if ((state_q == ST_MUL) && mul_done) begin
        out_d       = mul_product;
        status_d    = mul_status;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      if (accept) begin
        if (is_mul_cmd(bus_io.cmd)) begin
          state_d   = ST_MUL;
          mul_start = 1'b1;
        end else begin
          out_d       = alu_res;
          status_d    = alu_status;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      status_q    <= status_d;
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out       = out_q;
  assign bus_io.status    = status_q;
  assign bus_io.busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected results, a negedge monitor checks consumes.
module tb_alu_mc;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] o;
    logic [3:0]  s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus_io  (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic ci, input bit push,
                       input logic [31:0] eo, input logic [3:0] es);
    int n = 0;
    exp_t e;
    bus.cmd      = c;
    bus.in1      = a;
    bus.in2      = b;
    bus.in3      = d;
    bus.carry_in = ci;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("issue_timeout", 64'(bus.in_ready), 64'd1);
    if (push) begin
      e.o = eo;
      e.s = es;
      sb_q.push_back(e);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 64'(bus.out), 64'hDEAD_0000_0000_0000);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_out", 64'(bus.out), 64'(e.o));
        check("sb_status", 64'(bus.status), 64'(e.s));
      end
    end
  end

  logic [3:0]  t_cmd[8] = '{CMD_SUB, CMD_SBC, CMD_MOV, CMD_MVN, CMD_ADC, CMD_AND, CMD_ORR, 4'b1111};
  logic [31:0] t_a[8]   = '{32'd5, 32'd5, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                            32'hF000_0000, 32'hAAAA_AAAA};
  logic [31:0] t_b[8]   = '{32'd7, 32'd3, 32'h0, 32'h0000_FFFF, 32'h0, 32'h0FF0_0FF0,
                            32'h1, 32'hAAAA_AAAA};
  logic        t_ci[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] t_eo[8]  = '{32'hFFFF_FFFE, 32'd1, 32'h0, 32'hFFFF_0000, 32'h0, 32'h00F0_00F0,
                            32'hF000_0001, 32'h0};
  logic [3:0]  t_es[8]  = '{4'b1010, 4'b0000, 4'b0100, 4'b1000, 4'b0110, 4'b0000,
                            4'b1000, 4'b0100};

  initial begin
    int  cyc;
    bit  ok;
    int  streak;
    bus.in_valid  = 1'b0;
    bus.cmd       = 4'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.in3       = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_status", 64'(bus.status), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Signed overflow on ADD, with one-cycle latency.
    issue(CMD_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 4'b1001);
    @(negedge clk);
    check("add_latency", 64'(bus.out_valid), 64'd1);
    step();

    // SUB 0x80000000-1: signed overflow without borrow.
    issue(CMD_SUB, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0001);
    for (int i = 0; i < 8; i++) issue(t_cmd[i], t_a[i], t_b[i], 32'h0, t_ci[i], 1'b1, t_eo[i], t_es[i]);
    repeat (2) step();

    // MUL: exactly 32 cycles, busy and not ready throughout.
    issue(CMD_MUL, 32'h1_0000, 32'h1_0000, 32'h0, 1'b0, 1'b1, 32'h0, 4'b0100);
    cyc = 0;
    ok  = 1'b1;
    while (cyc < 100) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (!(bus.busy && !bus.in_ready)) ok = 1'b0;
      cyc++;
    end
    check("mul_latency", 64'(cyc), 64'd32);
    check("mul_busy_throughout", 64'(ok), 64'd1);
    check("mul_busy_done", 64'(bus.busy), 64'd0);
    step();

    // MLA with the consumer stalled for 5 cycles.
    bus.out_ready = 1'b0;
    issue(CMD_MLA, 32'd7, 32'd6, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h29, 4'b0000);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (bus.out_valid) break;
      cyc++;
    end
    check("mla_latency", 64'(cyc), 64'd32);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mla_hold_out", 64'(bus.out), 64'h29);
      if (!(bus.out_valid && !bus.in_ready && bus.status == 4'b0000)) ok = 1'b0;
    end
    check("mla_hold_ctrl", 64'(ok), 64'd1);
    step();
    bus.out_ready = 1'b1;
    step();

    // Flush sampled on the 10th multiply edge kills the multiply.
    issue(CMD_MUL, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0, 32'h0, 4'b0);
    repeat (8) step();
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    step();
    issue(CMD_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 1'b1, 32'd2, 4'b0000);
    @(negedge clk);
    check("post_flush_latency", 64'(bus.out_valid), 64'd1);
    step();
    repeat (40) step();
    check("flush_no_result", 64'(bus.out_valid), 64'd0);

    // Eight back-to-back ADDs.
    streak = 0;
    bus.cmd      = CMD_ADD;
    bus.carry_in = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      bus.in1 = 32'(i);
      bus.in2 = 32'd100;
      e.o = 32'(100 + i);
      e.s = 4'b0000;
      sb_q.push_back(e);
      check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
      if (i > 0 && bus.out_valid) streak++;
      step();
    end
    if (bus.out_valid) streak++;
    bus.in_valid = 1'b0;
    step();
    check("b2b_streak", 64'(streak), 64'd8);
    check("b2b_drained", 64'(bus.out_valid), 64'd0);

    // Async reset in the middle of a multiply.
    issue(CMD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 4'b0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("mrst_out", 64'(bus.out), 64'd0);
    check("mrst_status", 64'(bus.status), 64'd0);
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_in_ready", 64'(bus.in_ready), 64'd0);
    #20;
    step();
    rst_n = 1'b1;
    repeat (40) step();
    check("mrst_no_result", 64'(bus.out_valid), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
